// File: rtl/ohs_boost_pwm_l1.sv
// ohs_boost_pwm_l1
// Edge-aligned PWM generator that drives the level-1 boost model. A sawtooth
// carrier counter is compared against a duty-derived threshold to produce the
// switch gate. A programmable prescaler produces the model's integration strobe.
// Period and compare value are double-buffered: they only take effect at a
// period boundary, or at any time while the modulator is idle.
//
// Ports
//   aclk     in   clock
//   resetn   in   synchronous active-low reset
//   enable   in   1 = modulator running, 0 = outputs idle
//   period   in   carrier period in aclk cycles
//   duty     in   signed duty command, fixed point with data_decimal fraction bits
//   ce_div   in   ce strobe divider (0 behaves as 1), sampled live
//   S1_pwm   out  switch gate (1 = switch closed)
//   ce       out  one-cycle integration strobe
//   sync     out  one-cycle pulse on the first cycle of each period
//   cmp_cnt  out  compare value currently in use
module ohs_boost_pwm_l1 #(
   parameter int data_width   = 32,
   parameter int data_decimal = 22,
   parameter int cnt_width    = 16
) (
   input  logic                         aclk,
   input  logic                         resetn,
   input  logic                         enable,
   input  logic [cnt_width-1:0]         period,
   input  logic signed [data_width-1:0] duty,
   input  logic [cnt_width-1:0]         ce_div,
   output logic                         S1_pwm,
   output logic                         ce,
   output logic                         sync,
   output logic [cnt_width-1:0]         cmp_cnt
);

   localparam longint unsigned         one_ll   = 64'd1 << data_decimal;
   localparam logic [data_width-1:0]   duty_one = data_width'(one_ll);
   localparam logic [cnt_width-1:0]    cnt_one  = cnt_width'(1);

   logic [cnt_width-1:0]    cnt;
   logic [cnt_width-1:0]    psc;
   logic [cnt_width-1:0]    period_sh;
   logic [cnt_width-1:0]    cmp_sh;
   logic [data_width-1:0]   duty_clamped;
   logic [2*data_width-1:0] prod;
   logic [cnt_width-1:0]    cmp_next;
   logic [cnt_width-1:0]    div;
   logic                    run;
   logic                    wrap;
   logic                    shadow_load;
   logic                    psc_last;

   // Clamp duty into [0, 1.0] so the compare value never exceeds the period.
   always_comb begin
      duty_clamped = duty;
      if (duty[data_width-1])
         duty_clamped = '0;
      else if (duty > $signed(duty_one))
         duty_clamped = duty_one;
   end

   assign prod     = {{data_width{1'b0}}, duty_clamped}
                   * {{(2*data_width-cnt_width){1'b0}}, period};
   assign cmp_next = cnt_width'(prod >> data_decimal);

   assign run         = (period_sh != '0);
   assign wrap        = run && (cnt == period_sh - cnt_one);
   // A zero shadow period keeps reloading so a fresh period is picked up at once.
   assign shadow_load = !enable || !run || wrap;

   assign div      = (ce_div == '0) ? cnt_one : ce_div;
   // Using >= lets the prescaler recover immediately when ce_div is lowered
   // below its current value.
   assign psc_last = (psc >= div - cnt_one);

   always_ff @(posedge aclk) begin
      if (!resetn) begin
         cnt       <= '0;
         psc       <= '0;
         period_sh <= '0;
         cmp_sh    <= '0;
         S1_pwm    <= 1'b0;
         sync      <= 1'b0;
         ce        <= 1'b0;
      end else begin
         if (shadow_load) begin
            period_sh <= period;
            cmp_sh    <= cmp_next;
         end

         if (!enable || !run || wrap)
            cnt <= '0;
         else
            cnt <= cnt + cnt_one;

         S1_pwm <= enable && run && (cnt < cmp_sh);
         sync   <= enable && run && (cnt == '0);

         if (!enable) begin
            psc <= '0;
            ce  <= 1'b0;
         end else begin
            psc <= psc_last ? '0 : psc + cnt_one;
            ce  <= (psc == div - cnt_one);
         end
      end
   end

   assign cmp_cnt = cmp_sh;

endmodule
